// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises {op, data} RAM commands MSB first under ss_n and returns read-data bytes.
// Optional macro SPI_MASTER_TXN_CNT_EN adds a 16-bit completed-frame counter output txn_cnt.
module spi_master_ctrl #(
  parameter int RD_LATENCY = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso
`ifdef SPI_MASTER_TXN_CNT_EN
  ,
  output logic [15:0] txn_cnt
`endif
);

  // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready are both high;
  // cmd_ready is high only in IDLE and a request seen while not ready is ignored, not queued.

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_WAIT,
    S_RECV,
    S_END
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(9);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(7);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       shreg_q, shreg_d;
  logic             rd_q, rd_d;
  logic [7:0]       rx_q, rx_d;
  logic             ss_n_q, ss_n_d;
  logic             mosi_q, mosi_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
`ifdef SPI_MASTER_TXN_CNT_EN
  logic [15:0]      txn_cnt_q, txn_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    rd_d        = rd_q;
    rx_d        = rx_q;
    ss_n_d      = ss_n_q;
    mosi_d      = 1'b0;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = S_START;
          shreg_d     = {cmd_op, cmd_data};
          rd_d        = (cmd_op == 2'b11);
          cnt_d       = '0;
          ss_n_d      = 1'b0;
          busy_d      = 1'b1;
          cmd_ready_d = 1'b0;
        end
      end
      // START holds mosi low for the slave's command-check cycle while loading bit 9
      S_START: begin
        state_d = S_SHIFT;
        mosi_d  = shreg_q[9];
        shreg_d = {shreg_q[8:0], 1'b0};
        cnt_d   = '0;
      end
      S_SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = '0;
          if (rd_q) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_END;
            ss_n_d  = 1'b1;
          end
        end else begin
          mosi_d  = shreg_q[9];
          shreg_d = {shreg_q[8:0], 1'b0};
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_RECV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RECV: begin
        rx_d = {rx_q[6:0], miso};
        if (cnt_q == RECV_LAST) begin
          state_d     = S_END;
          cnt_d       = '0;
          ss_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {rx_q[6:0], miso};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_END: begin
        state_d     = S_IDLE;
        ss_n_d      = 1'b1;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        cnt_d       = '0;
        ss_n_d      = 1'b1;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

`ifdef SPI_MASTER_TXN_CNT_EN
  // END is only ever entered from SHIFT or RECV, so this fires once per completed frame
  always_comb begin
    txn_cnt_d = txn_cnt_q;
    if (state_d == S_END && state_q != S_END) begin
      txn_cnt_d = txn_cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      rd_q        <= 1'b0;
      rx_q        <= '0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef SPI_MASTER_TXN_CNT_EN
      txn_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      rd_q        <= rd_d;
      rx_q        <= rx_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef SPI_MASTER_TXN_CNT_EN
      txn_cnt_q   <= txn_cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign ss_n      = ss_n_q;
  assign mosi      = mosi_q;
`ifdef SPI_MASTER_TXN_CNT_EN
  assign txn_cnt   = txn_cnt_q;
`endif

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Host-side SPI initiator for the SPI-slave/single-port-RAM subsystem. Accepts one RAM command per handshake (write-address, write-data, read-address, read-data) and serialises it as a 10-bit MOSI frame {op[1:0], data[7:0]}, MSB first, framed by ss_n. For read-data it captures the 8-bit RAM byte returned on MISO and presents it on a one-cycle response strobe. SPI bit clock equals clk; the slave samples on the rising edge.

Parameters:
RD_LATENCY, 2, idle cycles between the last MOSI bit of a read-data frame and the first MISO sample (range 1..15)
CNT_W, 4, width of the internal bit/wait counter

Ports:
clk  input  1  system clock, also the SPI bit clock
rst_n  input  1  reset, synchronous, active-low
cmd_valid  input  1  host command valid
cmd_ready  output  1  block idle and able to accept a command
cmd_op  input  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
cmd_data  input  8  address or data byte; ignored content for 11 (sent as-is)
rsp_valid  output  1  one-cycle pulse: rsp_data holds read byte
rsp_data  output  8  byte captured from MISO
busy  output  1  high from acceptance until return to IDLE
ss_n  output  1  slave select, active-low
mosi  output  1  serial data to slave
miso  input  1  serial data from slave

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE, ss_n=1, mosi=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0x00, counters 0. Reset mid-frame aborts immediately: ss_n=1 on the next cycle, command dropped, no rsp_valid.
- All outputs registered. cmd_ready = (state==IDLE) && rst_n sampled high.
- Accept on cmd_valid && cmd_ready at edge E0: latch {cmd_op, cmd_data} into 10-bit shift register; busy=1.
- States: IDLE -> START -> SHIFT -> (WAIT -> RECV, op==11 only) -> END -> IDLE.
- START (after E0, 1 cycle): ss_n=0, mosi=0; the slave's command-check cycle.
- SHIFT (after E1..E10, 10 cycles): mosi = bit 9 down to bit 0; ss_n=0.
- After E11: op!=11 -> END; op==11 -> WAIT, mosi=0, ss_n=0.
- WAIT: exactly RD_LATENCY cycles, ss_n=0, mosi=0.
- RECV: 8 cycles; miso sampled at each rising edge, shifted in MSB first.
- After the 8th sample: END with rsp_valid=1 and rsp_data=captured byte for exactly that cycle. rsp_data holds its value until the next read completes.
- END (1 cycle): ss_n=1, mosi=0; then IDLE.
- Frame lengths with ss_n low: op 00/01/10 = 11 cycles; op 11 = 11+RD_LATENCY+8 cycles.
- Minimum ss_n-high gap between frames = 2 cycles (END + IDLE acceptance cycle).
- cmd_valid while not ready: ignored, not queued; host must hold it.
- No protocol checking of op ordering (rd-data without prior rd-addr is sent anyway).
- Counter widths: CNT_W must hold max(10, RD_LATENCY, 8).

Optional Feature:
SPI_MASTER_TXN_CNT_EN: when defined, adds output port txn_cnt[15:0], reset to 0, incremented by 1 in the END cycle of every completed frame (all ops), wrapping 0xFFFF -> 0x0000; aborted frames are not counted. When undefined, the port and counter do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> ss_n=1, mosi=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0x00.
- Write-address op=00 data=0xA5 -> ss_n low 11 cycles; mosi after START = 0,0,1,0,1,0,0,1,0,1; then ss_n=1; no rsp_valid.
- Full write/read: ops 00/0x3C, 01/0x96, 10/0x3C, 11/0x00 against a slave+RAM model, RD_LATENCY=2 -> single rsp_valid pulse with rsp_data=0x96, ss_n low 21 cycles on the rd-data frame.
- Back-to-back: cmd_valid held high with 4 commands -> each accepted only in IDLE, ss_n high exactly 2 cycles between frames, commands issued in order.
- Reset mid-frame: assert rst_n low during SHIFT bit 5 of op=11 -> ss_n=1 next cycle, no rsp_valid, next command frames correctly.
- SPI_MASTER_TXN_CNT_EN defined: preload via 0xFFFF completed frames (or force) then 1 more -> txn_cnt=0x0000; aborted frame leaves txn_cnt unchanged.
